fire3_squeeze_ofm_buf: RTL and testbench

- Feature-map buffer directly downstream of the fire3 squeeze conv stage.
- Captures each 16-channel output vector on the producer's sample pulse and serializes it into a single-write-port word RAM. Layout is pixel-major, channel-minor.
- Once the full WOUT x WOUT map is stored, it returns a feedback pulse to the producer and serves random-access reads to the fire3 expand stages.

---
 rtl/fire3_squeeze_ofm_buf.sv | 166 ++++++++++++++++
 tb/tb_fire3_squeeze_ofm_buf.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fire3_squeeze_ofm_buf.sv
// fire3 squeeze output feature-map buffer.
// Captures 16-channel vectors from the squeeze stage, serializes them into a
// pixel-major / channel-minor word RAM, then serves reads once the map is full.
module fire3_squeeze_ofm_buf #(
   parameter int unsigned WOUT   = 64,
   parameter int unsigned DSP_NO = 16,
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned AW     = $clog2(WOUT * WOUT * DSP_NO)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_sample,
   input  logic [WIDTH-1:0] i_wr_data [0:DSP_NO-1],
   input  logic             i_frame_clr,
   output logic             o_ram_feedback,
   output logic             o_full,
   output logic             o_busy,
   output logic             o_overflow,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_valid
);

   localparam int unsigned NPIX  = WOUT * WOUT;
   localparam int unsigned DEPTH = NPIX * DSP_NO;
   localparam int unsigned PW    = $clog2(NPIX) + 1;
   localparam int unsigned CW    = $clog2(DSP_NO);

   localparam logic [CW-1:0] CH_LAST  = CW'(DSP_NO - 1);
   localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
   localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StFull
   } state_e;

   state_e           r_state, w_state_d;
   logic [PW-1:0]    r_pix_cnt, w_pix_cnt_d;
   logic [CW-1:0]    r_ch_cnt, w_ch_cnt_d;
   logic [WIDTH-1:0] r_stage [0:DSP_NO-1];
   logic [WIDTH-1:0] r_mem   [0:DEPTH-1];
   logic             r_feedback;
   logic             r_overflow;
   logic             r_rd_valid;
   logic [WIDTH-1:0] r_rd_data;

   logic             w_capture;
   logic             w_wr_en;
   logic             w_last_write;
   logic             w_drop;
   logic             w_rd_hit;
   logic             w_rd_in_range;
   logic [AW-1:0]    w_wr_addr;

   // frame_clr has priority over every other event in the cycle it is seen
   assign w_capture     = (r_state == StIdle) && i_wr_sample && !i_frame_clr;
   assign w_wr_en       = (r_state == StWrite) && !i_frame_clr;
   assign w_last_write  = w_wr_en && (r_ch_cnt == CH_LAST);
   assign w_drop        = i_wr_sample && !i_frame_clr && (r_state != StIdle);
   assign w_rd_hit      = (r_state == StFull) && i_rd_en && !i_frame_clr;
   assign w_rd_in_range = {1'b0, i_rd_addr} < DEPTH_W;
   // DSP_NO is a power of two, so pixel*DSP_NO + channel is a plain concatenation
   assign w_wr_addr     = {r_pix_cnt[PW-2:0], r_ch_cnt};

   assign o_busy         = (r_state == StWrite);
   assign o_full         = (r_state == StFull);
   assign o_ram_feedback = r_feedback;
   assign o_overflow     = r_overflow;
   assign o_rd_valid     = r_rd_valid;
   assign o_rd_data      = r_rd_data;

   // Next-state and counter update for the capture/serialize FSM
   always_comb begin
      w_state_d   = r_state;
      w_pix_cnt_d = r_pix_cnt;
      w_ch_cnt_d  = r_ch_cnt;
      if (i_frame_clr) begin
         w_state_d   = StIdle;
         w_pix_cnt_d = '0;
         w_ch_cnt_d  = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_wr_sample) begin
                  w_state_d  = StWrite;
                  w_ch_cnt_d = '0;
               end
            end
            StWrite: begin
               w_ch_cnt_d = r_ch_cnt + CW'(1);
               if (r_ch_cnt == CH_LAST) begin
                  w_pix_cnt_d = r_pix_cnt + PW'(1);
                  w_state_d   = (r_pix_cnt == PIX_LAST) ? StFull : StIdle;
               end
            end
            StFull: begin
               w_state_d = StFull;
            end
            default: begin
               w_state_d = StIdle;
            end
         endcase
      end
   end

   // FSM state and counters
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= StIdle;
         r_pix_cnt <= '0;
         r_ch_cnt  <= '0;
      end else begin
         r_state   <= w_state_d;
         r_pix_cnt <= w_pix_cnt_d;
         r_ch_cnt  <= w_ch_cnt_d;
      end
   end

   // Status flags: completion pulse and sticky drop indicator
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_feedback <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_feedback <= w_last_write && (r_pix_cnt == PIX_LAST);
         if (i_frame_clr) begin
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Staging registers hold the captured vector while it is serialized
   always_ff @(posedge i_clk) begin
      if (w_capture) begin
         for (int i = 0; i < int'(DSP_NO); i++) begin
            r_stage[i] <= i_wr_data[i];
         end
      end
   end

   // Single write port; contents survive reset and frame_clr
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= r_stage[r_ch_cnt];
      end
   end

   // Registered read port, only live while the map is complete
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= w_rd_hit;
         if (w_rd_hit) begin
            r_rd_data <= w_rd_in_range ? r_mem[i_rd_addr] : '0;
         end
      end
   end

endmodule

// File: tb/tb_fire3_squeeze_ofm_buf.sv
// Randomized self-checking bench for fire3_squeeze_ofm_buf against a
// behavioural memory model (array of words indexed by pixel*DSP_NO+channel).
module tb_fire3_squeeze_ofm_buf;

   localparam int unsigned WOUT   = 12;
   localparam int unsigned DSP_NO = 16;
   localparam int unsigned WIDTH  = 16;
   localparam int unsigned NPIX   = WOUT * WOUT;
   localparam int unsigned DEPTH  = NPIX * DSP_NO;
   localparam int unsigned AW     = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             wr_sample = 1'b0;
   logic [WIDTH-1:0] wr_data [0:DSP_NO-1];
   logic             frame_clr = 1'b0;
   logic             ram_feedback, full, busy, overflow;
   logic             rd_en = 1'b0;
   logic [AW-1:0]    rd_addr = '0;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;

   int n_checks = 0;
   int n_errors = 0;
   int fb_cnt   = 0;
   int m_pix    = 0;
   logic [WIDTH-1:0] model_mem [0:DEPTH-1];
   logic [WIDTH-1:0] last_rd;

   always #5 clk = ~clk;

   fire3_squeeze_ofm_buf #(
      .WOUT  (WOUT),
      .DSP_NO(DSP_NO),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_wr_sample   (wr_sample),
      .i_wr_data     (wr_data),
      .i_frame_clr   (frame_clr),
      .o_ram_feedback(ram_feedback),
      .o_full        (full),
      .o_busy        (busy),
      .o_overflow    (overflow),
      .i_rd_en       (rd_en),
      .i_rd_addr     (rd_addr),
      .o_rd_data     (rd_data),
      .o_rd_valid    (rd_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (ram_feedback) fb_cnt++;
   endtask

   // One-cycle sample pulse; accepted vectors go into the model
   task automatic send(input bit rnd, input bit accept);
      for (int c = 0; c < int'(DSP_NO); c++) begin
         wr_data[c] = rnd ? WIDTH'($urandom) : WIDTH'(c + 1);
      end
      if (accept && m_pix < int'(NPIX)) begin
         for (int c = 0; c < int'(DSP_NO); c++) model_mem[m_pix * DSP_NO + c] = wr_data[c];
         m_pix++;
      end
      wr_sample = 1'b1;
      tick();
      wr_sample = 1'b0;
   endtask

   task automatic fill_frame();
      int k;
      fb_cnt = 0;
      for (int p = 0; p < int'(NPIX); p++) begin
         send(1'b1, 1'b1);
         if (p != int'(NPIX) - 1) begin
            int gap = $urandom_range(DSP_NO, DSP_NO + 5);
            for (int g = 0; g < gap; g++) tick();
         end
      end
      k = 0;
      while (!full && k < 40) begin
         tick();
         k++;
      end
      chk("full_latency", 32'(k), 32'(DSP_NO));
      chk("feedback_with_full", 32'(ram_feedback), 32'd1);
      tick();
      chk("feedback_width", 32'(ram_feedback), 32'd0);
      tick();
      chk("feedback_count", 32'(fb_cnt), 32'd1);
      chk("fill_overflow", 32'(overflow), 32'd0);
      chk("fill_busy", 32'(busy), 32'd0);
      chk("fill_full_held", 32'(full), 32'd1);
   endtask

   // Back-to-back reads; each result is checked on the following cycle
   task automatic readback(input int fixed [$], input int n_rand);
      int addrs [$];
      addrs = fixed;
      for (int i = 0; i < n_rand; i++) addrs.push_back(int'($urandom_range(0, (1 << AW) - 1)));
      for (int i = 0; i <= addrs.size(); i++) begin
         if (i > 0) begin
            logic [WIDTH-1:0] exp;
            exp = (addrs[i-1] < int'(DEPTH)) ? model_mem[addrs[i-1]] : '0;
            chk($sformatf("rd_valid[%0d]", addrs[i-1]), 32'(rd_valid), 32'd1);
            chk($sformatf("rd_data[%0d]", addrs[i-1]), 32'(rd_data), 32'(exp));
            last_rd = exp;
         end
         if (i < addrs.size()) begin
            rd_en   = 1'b1;
            rd_addr = AW'(addrs[i]);
         end else begin
            rd_en = 1'b0;
         end
         tick();
      end
      chk("rd_valid_drop", 32'(rd_valid), 32'd0);
      chk("rd_data_hold", 32'(rd_data), 32'(last_rd));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int busy_cycles;
      int fixed [$];
      for (int c = 0; c < int'(DSP_NO); c++) wr_data[c] = '0;

      // Reset state
      tick();
      tick();
      chk("rst_feedback", 32'(ram_feedback), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      rst_n = 1'b1;
      tick();

      // First vector, with an early second sample that must be dropped
      send(1'b0, 1'b1);
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_cycles++;
         wr_sample = (i == 4);
         if (i == 4) for (int c = 0; c < int'(DSP_NO); c++) wr_data[c] = WIDTH'($urandom);
         tick();
         if (i == 4) chk("overflow_set", 32'(overflow), 32'd1);
      end
      wr_sample = 1'b0;
      chk("busy_cycles", 32'(busy_cycles), 32'(DSP_NO));
      chk("pix_after_one", 32'(dut.r_pix_cnt), 32'd1);
      chk("full_after_one", 32'(full), 32'd0);
      chk("overflow_sticky", 32'(overflow), 32'd1);

      // Reads are ignored outside FULL
      rd_en   = 1'b1;
      rd_addr = '0;
      tick();
      tick();
      chk("idle_rd_valid", 32'(rd_valid), 32'd0);
      chk("idle_rd_data", 32'(rd_data), 32'd0);
      rd_en = 1'b0;

      // frame_clr wins over a coincident sample
      frame_clr = 1'b1;
      wr_sample = 1'b1;
      tick();
      frame_clr = 1'b0;
      wr_sample = 1'b0;
      m_pix     = 0;
      tick();
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_pix", 32'(dut.r_pix_cnt), 32'd0);

      // First full frame and readback
      fill_frame();
      fixed = '{0, 17, int'(DEPTH) - 1, int'(DEPTH), (1 << AW) - 1};
      readback(fixed, 24);

      // Sample in FULL is dropped
      send(1'b1, 1'b0);
      chk("full_overflow", 32'(overflow), 32'd1);
      chk("full_stays", 32'(full), 32'd1);
      chk("full_no_feedback", 32'(ram_feedback), 32'd0);

      // frame_clr in FULL, coincident with a read request
      frame_clr = 1'b1;
      rd_en     = 1'b1;
      rd_addr   = AW'(5);
      tick();
      frame_clr = 1'b0;
      rd_en     = 1'b0;
      m_pix     = 0;
      chk("fclr_full", 32'(full), 32'd0);
      chk("fclr_busy", 32'(busy), 32'd0);
      chk("fclr_overflow", 32'(overflow), 32'd0);
      chk("fclr_rd_valid", 32'(rd_valid), 32'd0);
      chk("fclr_rd_hold", 32'(rd_data), 32'(last_rd));

      // Asynchronous reset during cycle 8 of WRITE
      send(1'b1, 1'b1);
      for (int i = 0; i < 7; i++) tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_full", 32'(full), 32'd0);
      chk("arst_feedback", 32'(ram_feedback), 32'd0);
      chk("arst_overflow", 32'(overflow), 32'd0);
      chk("arst_rd_valid", 32'(rd_valid), 32'd0);
      chk("arst_rd_data", 32'(rd_data), 32'd0);
      tick();
      rst_n = 1'b1;
      m_pix = 0;
      tick();
      chk("arst_pix", 32'(dut.r_pix_cnt), 32'd0);
      chk("arst_ch", 32'(dut.r_ch_cnt), 32'd0);

      // Second frame starts at address 0 again
      fill_frame();
      fixed = '{};
      for (int a = 0; a < int'(DSP_NO); a++) fixed.push_back(a);
      fixed.push_back(int'(DEPTH) - 1);
      readback(fixed, 16);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
